id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// Operands resolved at capture; held operands pick up MEM/WB writes while stalled.
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [7:0]        ctrl_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rdreg1_i,
  input  logic [REG_AW-1:0] rdreg2_i,
  input  logic [DATA_W-1:0] rdata1_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic [REG_AW-1:0] wrreg_i,
  input  logic              regwrite_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_wrreg_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_wrreg_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] opa_o,
  output logic [DATA_W-1:0] opb_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [7:0]        ctrl_o,
  output logic [REG_AW-1:0] wrreg_o,
  output logic              regwrite_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o
);

  logic [DATA_W-1:0] opa_fwd_c;
  logic [DATA_W-1:0] opb_fwd_c;
  logic              opa_refresh_c;
  logic              opb_refresh_c;

  // Forward mux for incoming operands: EX/MEM beats MEM/WB beats the register heap.
  always_comb begin
    opa_fwd_c = rdata1_i;
    opb_fwd_c = rdata2_i;
    if (exmem_regwrite_i && (exmem_wrreg_i == rdreg1_i)) begin
      opa_fwd_c = exmem_data_i;
    end else if (memwb_regwrite_i && (memwb_wrreg_i == rdreg1_i)) begin
      opa_fwd_c = memwb_data_i;
    end
    if (exmem_regwrite_i && (exmem_wrreg_i == rdreg2_i)) begin
      opb_fwd_c = exmem_data_i;
    end else if (memwb_regwrite_i && (memwb_wrreg_i == rdreg2_i)) begin
      opb_fwd_c = memwb_data_i;
    end
  end

  // Held operand refresh: only a live instruction tracks the heap write port.
  always_comb begin
    opa_refresh_c = valid_o && memwb_regwrite_i && (memwb_wrreg_i == rs1_o);
    opb_refresh_c = valid_o && memwb_regwrite_i && (memwb_wrreg_i == rs2_o);
  end

  // Pipeline register: reset > flush > stall > capture.
  always_ff @(posedge CLK) begin
    if (!RST || flush_i) begin
      valid_o    <= 1'b0;
      opa_o      <= '0;
      opb_o      <= '0;
      imm_o      <= '0;
      ctrl_o     <= '0;
      wrreg_o    <= '0;
      regwrite_o <= 1'b0;
      rs1_o      <= '0;
      rs2_o      <= '0;
    end else if (stall_i) begin
      if (opa_refresh_c) opa_o <= memwb_data_i;
      if (opb_refresh_c) opb_o <= memwb_data_i;
    end else begin
      valid_o    <= valid_i;
      opa_o      <= opa_fwd_c;
      opb_o      <= opb_fwd_c;
      imm_o      <= imm_i;
      ctrl_o     <= ctrl_i;
      wrreg_o    <= wrreg_i;
      regwrite_o <= valid_i && regwrite_i;
      rs1_o      <= rdreg1_i;
      rs2_o      <= rdreg2_i;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the ID/EX register.
module tb_id_ex_stage;

  logic        CLK;
  logic        RST;
  logic        stall_i, flush_i, valid_i;
  logic [7:0]  ctrl_i;
  logic [15:0] imm_i;
  logic [3:0]  rdreg1_i, rdreg2_i;
  logic [15:0] rdata1_i, rdata2_i;
  logic [3:0]  wrreg_i;
  logic        regwrite_i;
  logic        exmem_regwrite_i;
  logic [3:0]  exmem_wrreg_i;
  logic [15:0] exmem_data_i;
  logic        memwb_regwrite_i;
  logic [3:0]  memwb_wrreg_i;
  logic [15:0] memwb_data_i;
  logic        valid_o;
  logic [15:0] opa_o, opb_o, imm_o;
  logic [7:0]  ctrl_o;
  logic [3:0]  wrreg_o;
  logic        regwrite_o;
  logic [3:0]  rs1_o, rs2_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        valid;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] imm;
    logic [7:0]  ctrl;
    logic [3:0]  wrreg;
    logic        regwrite;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } exp_t;

  exp_t model;

  id_ex_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .imm_i(imm_i),
    .rdreg1_i(rdreg1_i), .rdreg2_i(rdreg2_i),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .wrreg_i(wrreg_i), .regwrite_i(regwrite_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_wrreg_i(exmem_wrreg_i),
    .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_wrreg_i(memwb_wrreg_i),
    .memwb_data_i(memwb_data_i),
    .valid_o(valid_o), .opa_o(opa_o), .opb_o(opb_o), .imm_o(imm_o),
    .ctrl_o(ctrl_o), .wrreg_o(wrreg_o), .regwrite_o(regwrite_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value a reader of register rd would see: newest in-flight write wins.
  function automatic logic [15:0] read_reg(input logic [3:0] rd, input logic [15:0] heap);
    if (exmem_regwrite_i && exmem_wrreg_i == rd) return exmem_data_i;
    if (memwb_regwrite_i && memwb_wrreg_i == rd) return memwb_data_i;
    return heap;
  endfunction

  // Next expected register contents from the current inputs.
  function automatic exp_t predict(input exp_t cur);
    exp_t n;
    n = cur;
    if (!RST || flush_i) begin
      n = '0;
    end else if (stall_i) begin
      if (cur.valid && memwb_regwrite_i) begin
        if (memwb_wrreg_i == cur.rs1) n.opa = memwb_data_i;
        if (memwb_wrreg_i == cur.rs2) n.opb = memwb_data_i;
      end
    end else begin
      n.valid    = valid_i;
      n.regwrite = valid_i & regwrite_i;
      n.opa      = read_reg(rdreg1_i, rdata1_i);
      n.opb      = read_reg(rdreg2_i, rdata2_i);
      n.imm      = imm_i;
      n.ctrl     = ctrl_i;
      n.wrreg    = wrreg_i;
      n.rs1      = rdreg1_i;
      n.rs2      = rdreg2_i;
    end
    return n;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"},    16'(valid_o),    16'(model.valid));
    check({tag, ".opa"},      opa_o,           model.opa);
    check({tag, ".opb"},      opb_o,           model.opb);
    check({tag, ".imm"},      imm_o,           model.imm);
    check({tag, ".ctrl"},     16'(ctrl_o),     16'(model.ctrl));
    check({tag, ".wrreg"},    16'(wrreg_o),    16'(model.wrreg));
    check({tag, ".regwrite"}, 16'(regwrite_o), 16'(model.regwrite));
    check({tag, ".rs1"},      16'(rs1_o),      16'(model.rs1));
    check({tag, ".rs2"},      16'(rs2_o),      16'(model.rs2));
  endtask

  // One clock: predict, take the edge, sample 1 time unit later, compare.
  task automatic step(input string tag);
    exp_t nxt;
    nxt = predict(model);
    @(posedge CLK);
    #1;
    model = nxt;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    RST = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    ctrl_i = '0; imm_i = '0; rdreg1_i = '0; rdreg2_i = '0;
    rdata1_i = '0; rdata2_i = '0; wrreg_i = '0; regwrite_i = 1'b0;
    exmem_regwrite_i = 1'b0; exmem_wrreg_i = '0; exmem_data_i = '0;
    memwb_regwrite_i = 1'b0; memwb_wrreg_i = '0; memwb_data_i = '0;
  endtask

  task automatic issue(input logic [3:0] r1, input logic [15:0] d1,
                       input logic [3:0] r2, input logic [15:0] d2);
    valid_i = 1'b1; regwrite_i = 1'b1; ctrl_i = 8'hA5; imm_i = 16'h1234; wrreg_i = 4'd7;
    rdreg1_i = r1; rdata1_i = d1; rdreg2_i = r2; rdata2_i = d2;
  endtask

  initial begin
    model = '0;
    idle_inputs();
    // Reset: pre-load garbage on inputs to prove reset wins.
    RST = 1'b0; stall_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; imm_i = 16'hFFFF;
    step("reset");
    step("reset2");
    check("reset_valid", 16'(valid_o), 16'h0);
    check("reset_opa", opa_o, 16'h0);
    idle_inputs();

    // Plain capture, first edge after reset release.
    issue(4'd8, 16'hF0F0, 4'd9, 16'h0000);
    step("plain");
    check("plain_opa", opa_o, 16'hF0F0);
    check("plain_rs1", 16'(rs1_o), 16'd8);
    check("plain_valid", 16'(valid_o), 16'd1);

    // Double-forward priority.
    issue(4'd3, 16'h1111, 4'd4, 16'h2222);
    exmem_regwrite_i = 1'b1; exmem_wrreg_i = 4'd3; exmem_data_i = 16'hABCD;
    memwb_regwrite_i = 1'b1; memwb_wrreg_i = 4'd3; memwb_data_i = 16'hDDDD;
    step("dfwd_ex");
    check("dfwd_ex_opa", opa_o, 16'hABCD);
    exmem_regwrite_i = 1'b0;
    step("dfwd_wb");
    check("dfwd_wb_opa", opa_o, 16'hDDDD);
    idle_inputs();

    // Stall refresh from MEM/WB only.
    issue(4'd8, 16'hF0F0, 4'd9, 16'h0000);
    step("sr_cap");
    idle_inputs();
    stall_i = 1'b1; memwb_regwrite_i = 1'b1; memwb_wrreg_i = 4'd9; memwb_data_i = 16'hDDDD;
    step("sr_wb");
    check("sr_wb_opb", opb_o, 16'hDDDD);
    check("sr_wb_opa", opa_o, 16'hF0F0);
    memwb_regwrite_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_wrreg_i = 4'd9; exmem_data_i = 16'h5555;
    step("sr_ex");
    check("sr_ex_opb", opb_o, 16'hDDDD);

    // Flush beats stall; bubble is never refreshed.
    idle_inputs();
    stall_i = 1'b1; flush_i = 1'b1;
    step("flush");
    check("flush_valid", 16'(valid_o), 16'h0);
    flush_i = 1'b0; memwb_regwrite_i = 1'b1; memwb_wrreg_i = 4'd0; memwb_data_i = 16'hBEEF;
    step("bubble_hold");
    check("bubble_opa", opa_o, 16'h0);

    // Mid-stall reset, then immediate capture.
    idle_inputs();
    issue(4'd2, 16'h7777, 4'd1, 16'h6666);
    step("ms_cap");
    idle_inputs();
    stall_i = 1'b1;
    step("ms_hold");
    RST = 1'b0;
    step("ms_rst");
    check("ms_rst_opa", opa_o, 16'h0);
    RST = 1'b1; stall_i = 1'b0;
    issue(4'd5, 16'h3C3C, 4'd6, 16'h4B4B);
    step("ms_new");
    check("ms_new_opa", opa_o, 16'h3C3C);

    // Per-operand independence, register 5/6 and index 0.
    idle_inputs();
    issue(4'd5, 16'h0000, 4'd5, 16'h0000);
    memwb_regwrite_i = 1'b1; memwb_wrreg_i = 4'd5; memwb_data_i = 16'h0F0F;
    step("ind_both");
    check("ind_both_opb", opb_o, 16'h0F0F);
    rdreg2_i = 4'd6;
    step("ind_one");
    check("ind_one_opa", opa_o, 16'h0F0F);
    check("ind_one_opb", opb_o, 16'h0000);
    issue(4'd0, 16'h1234, 4'd0, 16'h1234);
    exmem_regwrite_i = 1'b1; exmem_wrreg_i = 4'd0; exmem_data_i = 16'h9999;
    step("zero_reg");
    check("zero_reg_opa", opa_o, 16'h9999);

    // Random traffic; small index space keeps forwarding hits frequent.
    for (int i = 0; i < 600; i++) begin
      RST              = ($urandom_range(0, 39) != 0);
      flush_i          = ($urandom_range(0, 9) == 0);
      stall_i          = ($urandom_range(0, 2) == 0);
      valid_i          = ($urandom_range(0, 3) != 0);
      regwrite_i       = 1'($urandom);
      ctrl_i           = 8'($urandom);
      imm_i            = 16'($urandom);
      wrreg_i          = 4'($urandom);
      rdreg1_i         = 4'($urandom_range(0, 3));
      rdreg2_i         = 4'($urandom_range(0, 3));
      rdata1_i         = 16'($urandom);
      rdata2_i         = 16'($urandom);
      exmem_regwrite_i = 1'($urandom);
      exmem_wrreg_i    = 4'($urandom_range(0, 3));
      exmem_data_i     = 16'($urandom);
      memwb_regwrite_i = 1'($urandom);
      memwb_wrreg_i    = 4'($urandom_range(0, 3));
      memwb_data_i     = 16'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
